// File: rtl/decode_ctrl_pipe.sv
// MIPS ID-stage control decoder with a registered ID/EX control slot.
// Handles jump/branch squash slots, load-use interlock, downstream hold and a sticky illegal-opcode flag.
module decode_ctrl_pipe #(
  parameter int unsigned ALUCTR_W   = 5,
  parameter int unsigned KILL_SLOTS = 1,
  parameter int unsigned EN_LOADUSE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [31:0]         instruction,
  input  logic                hold,
  input  logic                branch_taken,
  output logic                out_valid,
  output logic                regdst,
  output logic                branch,
  output logic                memtoreg,
  output logic                alusrc1,
  output logic                alusrc2,
  output logic                regwrite,
  output logic                extop,
  output logic [1:0]          jump,
  output logic [1:0]          memread,
  output logic [1:0]          memwrite,
  output logic [ALUCTR_W-1:0] aluctr,
  output logic [4:0]          dest,
  output logic                stall_req,
  output logic                illegal_op
);

  typedef enum logic [1:0] {RUN, KILL, STALL} state_t;

  typedef struct packed {
    logic       valid;
    logic       regdst;
    logic       branch;
    logic       memtoreg;
    logic       alusrc1;
    logic       alusrc2;
    logic       regwrite;
    logic       extop;
    logic [1:0] jump;
    logic [1:0] memread;
    logic [1:0] memwrite;
    logic [4:0] alu;
    logic [4:0] dest;
  } ctrl_t;

  localparam logic [1:0] KILL_LOAD = 2'(KILL_SLOTS);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d, dec;
  logic       illegal_q, illegal_d;

  logic [5:0] op, func;
  logic [4:0] rs, rt, rd;
  logic       is_r, is_ialu, is_load, is_store, is_branch, is_jmp, supported;
  logic       uses_rt, hazard;

  assign op   = instruction[31:26];
  assign rs   = instruction[25:21];
  assign rt   = instruction[20:16];
  assign rd   = instruction[15:11];
  assign func = instruction[5:0];

  // Instruction class and decoded control word
  always_comb begin
    is_r      = (op == 6'h00);
    is_ialu   = op inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    is_load   = op inside {6'h20, 6'h21, 6'h23};
    is_store  = op inside {6'h28, 6'h29, 6'h2B};
    is_branch = (op inside {6'h04, 6'h05, 6'h06, 6'h07}) ||
                ((op == 6'h01) && (rt inside {5'd0, 5'd1}));
    supported = is_r | is_ialu | is_load | is_store | is_branch |
                (op == 6'h02) | (op == 6'h03);
    uses_rt   = is_r | (op == 6'h04) | (op == 6'h05) | is_store;

    dec          = '0;
    dec.valid    = 1'b1;
    dec.regdst   = is_r;
    dec.branch   = is_branch;
    dec.memtoreg = is_load;
    dec.alusrc1  = is_r && ((func == 6'b000000) || (func[5:1] == 5'b00001));
    dec.alusrc2  = is_load | is_store | is_ialu;
    dec.regwrite = is_r | is_ialu | is_load | (op == 6'h03);
    dec.extop    = (op inside {6'h08, 6'h09, 6'h0A, 6'h0B}) | is_load | is_store | is_branch;
    if (op == 6'h02)                     dec.jump = 2'b01;
    else if (op == 6'h03)                dec.jump = 2'b11;
    else if (is_r && func == 6'b001000)  dec.jump = 2'b10;
    case (op)
      6'h20:   dec.memread  = 2'b01;
      6'h21:   dec.memread  = 2'b10;
      6'h23:   dec.memread  = 2'b11;
      6'h28:   dec.memwrite = 2'b01;
      6'h29:   dec.memwrite = 2'b10;
      6'h2B:   dec.memwrite = 2'b11;
      default: ;
    endcase
    case (op)
      6'h00:   dec.alu = {func[5], func[3:0]};
      6'h08:   dec.alu = 5'b10000;
      6'h09, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B:
               dec.alu = 5'b10001;
      6'h0A:   dec.alu = 5'b11010;
      6'h0B:   dec.alu = 5'b11011;
      6'h0C:   dec.alu = 5'b10100;
      6'h0D:   dec.alu = 5'b10101;
      6'h0E:   dec.alu = 5'b10110;
      6'h0F:   dec.alu = 5'b11000;
      6'h04:   dec.alu = 5'b10011;
      6'h03:   dec.alu = 5'b01000;
      default: dec.alu = 5'b00000;
    endcase
    dec.dest = is_r ? rd : ((op == 6'h03) ? 5'd31 : rt);
    // All-zero word is the canonical nop: a valid slot with no side effects
    if (instruction == 32'h0) begin
      dec       = '0;
      dec.valid = 1'b1;
    end
    is_jmp = (dec.jump != 2'b00);
  end

  // Load-use interlock against the load currently sitting in ID/EX
  assign hazard = ctrl_q.valid && ctrl_q.memtoreg && (ctrl_q.dest != 5'd0) && in_valid &&
                  ((rs == ctrl_q.dest) || (uses_rt && (rt == ctrl_q.dest)));
  assign stall_req = (EN_LOADUSE != 0) && !rst && (state_q == RUN) && !branch_taken && hazard;

  // Next-state and next control slot
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (!hold) begin
      ctrl_d = '0;
      if (branch_taken) begin
        state_d = (KILL_SLOTS > 0) ? KILL : RUN;
        cnt_d   = KILL_LOAD;
      end else if (state_q == KILL) begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      end else if (stall_req) begin
        state_d = STALL;
      end else begin
        state_d = RUN;
        if (in_valid) begin
          if (supported) begin
            ctrl_d = dec;
            if (is_jmp && (KILL_SLOTS > 0)) begin
              state_d = KILL;
              cnt_d   = KILL_LOAD;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      cnt_q     <= 2'd0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = ctrl_q.valid;
  assign regdst     = ctrl_q.regdst;
  assign branch     = ctrl_q.branch;
  assign memtoreg   = ctrl_q.memtoreg;
  assign alusrc1    = ctrl_q.alusrc1;
  assign alusrc2    = ctrl_q.alusrc2;
  assign regwrite   = ctrl_q.regwrite;
  assign extop      = ctrl_q.extop;
  assign jump       = ctrl_q.jump;
  assign memread    = ctrl_q.memread;
  assign memwrite   = ctrl_q.memwrite;
  assign aluctr     = ALUCTR_W'(ctrl_q.alu);
  assign dest       = ctrl_q.dest;
  assign illegal_op = illegal_q;

endmodule

// File: doc/decode_ctrl_pipe.md
DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

Interface
REQ-001 Parameter ALUCTR_W, default 5, ALU control width; legal 5..8; upper bits zero-filled.
REQ-002 Parameter KILL_SLOTS, default 1, squashed slots after a jump or taken branch; legal 0..3.
REQ-003 Parameter EN_LOADUSE, default 1; 1 enables the load-use interlock, 0 disables it (stall_req tied 0).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  instruction is valid this cycle.
REQ-007 instruction  input  32  MIPS instruction in ID.
REQ-008 hold  input  1  downstream freeze; all state and outputs keep their value.
REQ-009 branch_taken  input  1  EX resolved a taken branch this cycle.
REQ-010 out_valid  output  1  ID/EX slot holds a real instruction.
REQ-011 regdst, branch, memtoreg, alusrc1, alusrc2, regwrite, extop  output  1 each  registered control bits.
REQ-012 jump  output  2  00 none, 01 j, 10 jr, 11 jal.
REQ-013 memread, memwrite  output  2 each  00 none, 01 byte, 10 half, 11 word.
REQ-014 aluctr  output  ALUCTR_W  ALU operation code.
REQ-015 dest  output  5  write register: rd (R), 31 (jal), rt otherwise.
REQ-016 stall_req  output  1  combinational; IF/ID must hold instruction when 1.
REQ-017 illegal_op  output  1  sticky unsupported-opcode flag.

Function
REQ-018 Outputs SHALL be registered; decode of instruction appears one cycle later (latency 1).
REQ-019 Supported: R-type, addi, addiu, slti, sltiu, andi, ori, xori, lui, beq, bne, bgez, bltz, bgtz, blez, lb, lh, lw, sb, sh, sw, j, jal.
REQ-020 Decode SHALL be: regdst=R; branch=any branch; memtoreg=load; alusrc1=R with func 000000 or func[5:1]=00001; alusrc2=load|store|I-ALU; regwrite=R|I-ALU|load|jal; extop=addi|addiu|slti|sltiu|load|store|branch.
REQ-021 aluctr SHALL be {func[5],func[3:0]} for R; addi 10000, addiu/load/store 10001, slti 11010, sltiu 11011, andi 10100, ori 10101, xori 10110, lui 11000, beq 10011, jal 01000, others 0; zero-extended to ALUCTR_W.
REQ-022 A bubble SHALL be all control outputs 0, dest 0, out_valid 0.
REQ-023 in_valid=0 SHALL register a bubble.
REQ-024 instruction==0 (nop) SHALL register all controls 0 with out_valid=1.
REQ-025 Unsupported opcode SHALL register a bubble and set illegal_op; illegal_op cleared only by rst.
REQ-026 FSM states RUN, KILL, STALL; reset state RUN; 2-bit kill counter.
REQ-027 RUN->KILL when a valid j/jr/jal is registered or branch_taken=1, with KILL_SLOTS>0; counter loads KILL_SLOTS.
REQ-028 In KILL each accepted cycle registers a bubble and decrements counter; at count 1 -> RUN.
REQ-029 branch_taken in KILL SHALL reload counter to KILL_SLOTS.
REQ-030 Load-use: registered slot is a load, dest!=0, and valid incoming instruction reads dest (rs; also rt for R, beq, bne, stores) -> stall_req=1, bubble registered, RUN->STALL.
REQ-031 STALL->RUN next cycle unconditionally; stall_req=0 in STALL.
REQ-032 Priority: rst > hold > branch_taken > load-use stall > normal decode.
REQ-033 hold=1 SHALL freeze FSM, counter, illegal_op and all registered outputs; stall_req still computed.
REQ-034 Jumps/branches in killed slots SHALL NOT retrigger KILL.

Reset
REQ-035 rst=1 SHALL, at the next edge, set all outputs to bubble values, illegal_op=0, state RUN, counter 0, overriding hold and mid-KILL/STALL.
REQ-036 stall_req SHALL be 0 while rst=1.

Verification
REQ-037 addi $t0,$t1,5 (0x21280005) -> next cycle regwrite=1, alusrc2=1, extop=1, aluctr=10000, dest=8, out_valid=1.
REQ-038 lw $t0,0($s0) then add $t1,$t0,$t2 -> stall_req=1 one cycle, one bubble, add issued the following cycle.
REQ-039 KILL_SLOTS=2: j then two valid instructions -> jump=01 registered, then two bubbles, third instruction decoded.
REQ-040 op 0x3F -> bubble registered, illegal_op=1 and stays 1 until rst.
REQ-041 hold=1 for 3 cycles mid-KILL -> outputs and counter unchanged, kill resumes after release.
REQ-042 rst asserted in STALL -> next cycle all outputs 0, state RUN, no stall_req.
